// File: rtl/car_light_pkg.sv
// Shared lamp-mode encodings and a width helper for the lamp controller.
package car_light_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  // Bits needed for a counter of n states (0..n-1), never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/car_light_if.sv
// Mode/hazard in, lamp/done/phase out between the driving-state FSM and the LED pins.
interface car_light_if #(
  parameter int NUM_CH = 2
);
  logic [2*NUM_CH-1:0] mode;
  logic                hazard;
  logic [NUM_CH-1:0]   lamp;
  logic [NUM_CH-1:0]   done;
  logic                phase;

  modport master (output mode, hazard, input lamp, done, phase);
  modport slave  (input mode, hazard, output lamp, done, phase);
endinterface

// File: rtl/blink_phase_gen.sv
// Shared half-period counter and blink phase; restart forces a fresh full on-half.
// Tick is combinational from cnt; no backpressure.
module blink_phase_gen
  import car_light_pkg::*;
#(
  parameter int HALF_PERIOD = 75
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase,
  output logic tick
);
  localparam int            CW   = cnt_w(HALF_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/car_light_ctrl.sv
// Multi-channel lamp controller: off/steady/blink/counted blink per lamp, hazard override.
// Lamp and done are registered, one cycle after inputs; no backpressure.
module car_light_ctrl
  import car_light_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int HALF_PERIOD = 75,
  parameter int PULSE_N     = 3
) (
  input  logic        clk,
  input  logic        rst,
  car_light_if.slave  bus
);
  localparam int            RW       = cnt_w(PULSE_N + 1);
  localparam logic [RW-1:0] PULSE_LD = RW'(PULSE_N);

  logic              blink_active_q;
  logic              want_blink;
  logic              restart;
  logic              phase;
  logic              tick;
  logic              eff_tick;
  logic              phase_next;
  logic [NUM_CH-1:0] blink_req;
  logic [NUM_CH-1:0] lamp_vec;
  logic [NUM_CH-1:0] done_vec;

  blink_phase_gen #(.HALF_PERIOD(HALF_PERIOD)) u_phase (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .phase   (phase),
    .tick    (tick)
  );

  // A restart swallows a coincident tick, so it can never count as an on->off edge.
  assign eff_tick   = tick & ~restart;
  assign phase_next = restart | (eff_tick ? ~phase : phase);
  assign want_blink = bus.hazard | (|blink_req);
  assign restart    = want_blink & ~blink_active_q;

  always_ff @(posedge clk) begin
    if (rst) blink_active_q <= 1'b0;
    else     blink_active_q <= want_blink;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]    m;
    logic [1:0]    prev_mode;
    logic [RW-1:0] rem;
    logic [RW-1:0] rem_next;
    logic          entry;
    logic          dec;
    logic          lamp_next;
    logic          done_next;
    logic          lamp_q;
    logic          done_q;

    assign m     = bus.mode[2*i +: 2];
    assign entry = (m == MODE_COUNT) && (prev_mode != MODE_COUNT);
    assign dec   = eff_tick & phase & (rem != '0) & ~bus.hazard;
    // A COUNT entry requests blinking at once so its first flash gets a full on-half.
    assign blink_req[i] = (m == MODE_BLINK) | ((m == MODE_COUNT) & (entry | (rem != '0)));

    always_comb begin
      rem_next  = rem;
      done_next = 1'b0;
      lamp_next = 1'b0;
      if (m != MODE_COUNT) begin
        rem_next = '0;
      end else if (entry) begin
        rem_next = PULSE_LD;
      end else if (dec) begin
        rem_next  = rem - RW'(1);
        done_next = (rem == RW'(1));
      end
      if (bus.hazard) begin
        lamp_next = phase_next;
      end else begin
        case (m)
          MODE_ON:    lamp_next = 1'b1;
          MODE_BLINK: lamp_next = phase_next;
          MODE_COUNT: lamp_next = phase_next & (rem_next != '0);
          default:    lamp_next = 1'b0;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        prev_mode <= MODE_OFF;
        rem       <= '0;
        lamp_q    <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        prev_mode <= m;
        rem       <= rem_next;
        lamp_q    <= lamp_next;
        done_q    <= done_next;
      end
    end

    assign lamp_vec[i] = lamp_q;
    assign done_vec[i] = done_q;
  end

  assign bus.lamp  = lamp_vec;
  assign bus.done  = done_vec;
  assign bus.phase = phase;

endmodule
